// File: rtl/morse_pkg.sv
// morse_pkg: state encoding, symbol codes and default timing shared by the Morse blocks
package morse_pkg;
    typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;
    localparam logic SYM_DOT = 1'b0;
    localparam logic SYM_DASH = 1'b1;
    localparam int DASH_UNITS = 3;
    localparam int GAP_UNITS = 3;
endpackage

// File: rtl/morse_unit_counter.sv
// morse_unit_counter: saturating tick counter with sync clear, used for mark and space timing
module morse_unit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en && cnt != '1)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer: times key marks/spaces in unit ticks, feeds the symbol shift register
// and hands each completed letter to the decoder over a valid/ack handshake.
module morse_key_sequencer
    import morse_pkg::*;
#(
    parameter int MAX_SYM = 5,
    parameter int DASH_UNITS = morse_pkg::DASH_UNITS,
    parameter int GAP_UNITS = morse_pkg::GAP_UNITS,
    parameter int CNT_W = 4,
    localparam int LEN_W = $clog2(MAX_SYM + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key,
    input  logic             tick,
    output logic             sr_enable,
    output logic             sr_si,
    output logic             sr_clear_n,
    output logic             letter_valid,
    output logic [LEN_W-1:0] letter_len,
    output logic             letter_ovf,
    input  logic             letter_ack
);
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0] cnt_inc;
    logic [LEN_W-1:0] sym_count, sym_nxt, len_nxt;
    logic ovf_flag, ovf_nxt, en_nxt, si_nxt, clr_n_nxt, valid_nxt, lovf_nxt, cnt_en;

    assign cnt_inc = {1'b0, cnt} + 1'b1;

    // any state change restarts the duration count, so each mark/space is timed from zero
    morse_unit_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk(clk),
        .reset(reset),
        .clear(state_nxt != state),
        .en(cnt_en),
        .cnt(cnt)
    );

    always_comb begin
        state_nxt = state;
        sym_nxt = sym_count;
        ovf_nxt = ovf_flag;
        en_nxt = 1'b0;
        si_nxt = sr_si;
        clr_n_nxt = 1'b1;
        valid_nxt = letter_valid;
        len_nxt = letter_len;
        lovf_nxt = letter_ovf;
        cnt_en = 1'b0;
        case (state)
            IDLE: state_nxt = key ? MARK : IDLE;
            MARK: begin
                if (key) begin
                    cnt_en = tick;
                end else if (cnt == '0) begin
                    state_nxt = (sym_count != '0) ? SPACE : IDLE;
                end else begin
                    en_nxt = 1'b1;
                    si_nxt = (cnt >= CNT_W'(DASH_UNITS)) ? SYM_DASH : SYM_DOT;
                    sym_nxt = (sym_count < LEN_W'(MAX_SYM)) ? sym_count + 1'b1 : sym_count;
                    ovf_nxt = ovf_flag | (sym_count >= LEN_W'(MAX_SYM));
                    state_nxt = SPACE;
                end
            end
            SPACE: begin
                if (key) begin
                    state_nxt = MARK;
                end else if (tick) begin
                    cnt_en = 1'b1;
                    if (cnt_inc == (CNT_W + 1)'(GAP_UNITS)) begin
                        state_nxt = EMIT;
                        valid_nxt = 1'b1;
                        len_nxt = sym_count;
                        lovf_nxt = ovf_flag;
                    end
                end
            end
            default: begin
                if (letter_ack) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    len_nxt = '0;
                    lovf_nxt = 1'b0;
                    clr_n_nxt = 1'b0;
                    sym_nxt = '0;
                    ovf_nxt = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sym_count <= '0;
            ovf_flag <= 1'b0;
            sr_enable <= 1'b0;
            sr_si <= 1'b0;
            sr_clear_n <= 1'b0;
            letter_valid <= 1'b0;
            letter_len <= '0;
            letter_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            sym_count <= sym_nxt;
            ovf_flag <= ovf_nxt;
            sr_enable <= en_nxt;
            sr_si <= si_nxt;
            sr_clear_n <= clr_n_nxt;
            letter_valid <= valid_nxt;
            letter_len <= len_nxt;
            letter_ovf <= lovf_nxt;
        end
    end
endmodule

// File: tb/tb_morse_key_sequencer.sv
// tb_morse_key_sequencer: directed letter table plus hand-written reset, glitch, stall and
// tick/release-collision sequences against a 5-bit shift register model.
module tb_morse_key_sequencer;
    logic clk = 1'b0;
    logic reset, key, tick, letter_ack;
    logic sr_enable, sr_si, sr_clear_n, letter_valid, letter_ovf;
    logic [2:0] letter_len;
    logic [4:0] q_m = '0;
    int pulses = 0;
    int overlap = 0;
    int tests = 0;
    int fails = 0;
    int base;

    typedef struct {
        int n;
        int t[6];
        int len;
        int ovf;
        int q;
    } vec_t;
    vec_t vecs[6];

    morse_key_sequencer dut (
        .clk(clk),
        .reset(reset),
        .key(key),
        .tick(tick),
        .sr_enable(sr_enable),
        .sr_si(sr_si),
        .sr_clear_n(sr_clear_n),
        .letter_valid(letter_valid),
        .letter_len(letter_len),
        .letter_ovf(letter_ovf),
        .letter_ack(letter_ack)
    );

    always #5 clk = ~clk;

    // shift register model (N = MAX_SYM) plus pulse bookkeeping, sampled mid-cycle
    always @(negedge clk) begin
        if (sr_enable) pulses <= pulses + 1;
        if (sr_enable && !sr_clear_n) overlap <= overlap + 1;
        if (!sr_clear_n) q_m <= '0;
        else if (sr_enable) q_m <= {q_m[3:0], sr_si};
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic k, input logic t);
        key = k;
        tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic mark(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) step(1'b1, 1'b0);
            step(1'b1, 1'b1);
        end
    endtask

    task automatic space(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end
    endtask

    task automatic do_ack();
        letter_ack = 1'b1;
        step(1'b0, 1'b0);
        letter_ack = 1'b0;
        chk("ack_valid_drop", int'(letter_valid), 0);
        chk("ack_len_zero", int'(letter_len), 0);
        chk("ack_ovf_zero", int'(letter_ovf), 0);
        chk("ack_clear_pulse", int'(sr_clear_n), 0);
        chk("ack_no_shift", int'(sr_enable), 0);
        step(1'b0, 1'b0);
        chk("ack_clear_release", int'(sr_clear_n), 1);
        chk("ack_q_zero", int'(q_m), 0);
    endtask

    initial begin
        vecs[0] = '{2, '{1, 3, 0, 0, 0, 0}, 2, 0, 5'b00001};
        vecs[1] = '{3, '{3, 1, 1, 0, 0, 0}, 3, 0, 5'b00100};
        vecs[2] = '{5, '{3, 3, 1, 3, 1, 0}, 5, 0, 5'b11010};
        vecs[3] = '{6, '{1, 1, 1, 1, 1, 1}, 5, 1, 5'b00000};
        vecs[4] = '{6, '{1, 1, 1, 1, 1, 3}, 5, 1, 5'b00001};
        vecs[5] = '{2, '{2, 4, 0, 0, 0, 0}, 2, 0, 5'b00001};
        reset = 1'b1;
        key = 1'b0;
        tick = 1'b0;
        letter_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sr_enable", int'(sr_enable), 0);
        chk("rst_sr_si", int'(sr_si), 0);
        chk("rst_sr_clear_n", int'(sr_clear_n), 0);
        chk("rst_letter_valid", int'(letter_valid), 0);
        chk("rst_letter_len", int'(letter_len), 0);
        chk("rst_letter_ovf", int'(letter_ovf), 0);
        reset = 1'b0;
        chk("rst_release_clear_held", int'(sr_clear_n), 0);
        step(1'b0, 1'b0);
        chk("rst_release_clear_n", int'(sr_clear_n), 1);

        // reset in the middle of a mark aborts it without a shift
        base = pulses;
        mark(1);
        step(1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_sr_clear_n", int'(sr_clear_n), 0);
        chk("midrst_sr_enable", int'(sr_enable), 0);
        chk("midrst_valid", int'(letter_valid), 0);
        key = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_clear_during", int'(sr_clear_n), 0);
        step(1'b0, 1'b0);
        chk("midrst_clear_after", int'(sr_clear_n), 1);
        repeat (8) step(1'b0, 1'b0);
        chk("midrst_no_pulse", pulses - base, 0);
        chk("midrst_no_letter", int'(letter_valid), 0);

        foreach (vecs[v]) begin
            base = pulses;
            for (int i = 0; i < vecs[v].n; i++) begin
                mark(vecs[v].t[i]);
                if (i < vecs[v].n - 1) space(1);
            end
            space(3);
            chk($sformatf("vec%0d_valid", v), int'(letter_valid), 1);
            chk($sformatf("vec%0d_len", v), int'(letter_len), vecs[v].len);
            chk($sformatf("vec%0d_ovf", v), int'(letter_ovf), vecs[v].ovf);
            chk($sformatf("vec%0d_pulses", v), pulses - base, vecs[v].n);
            chk($sformatf("vec%0d_q", v), int'(q_m), vecs[v].q);
            do_ack();
        end

        // glitch: key down for two cycles with no tick
        base = pulses;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, i % 4 == 3);
        chk("glitch_no_pulse", pulses - base, 0);
        chk("glitch_no_letter", int'(letter_valid), 0);
        mark(1);
        space(3);
        chk("glitch_next_valid", int'(letter_valid), 1);
        chk("glitch_next_len", int'(letter_len), 1);
        chk("glitch_next_pulses", pulses - base, 1);
        do_ack();

        // release and tick together at cnt=2 stays a dot
        base = pulses;
        mark(2);
        step(1'b0, 1'b1);
        chk("collide_enable", int'(sr_enable), 1);
        chk("collide_si_dot", int'(sr_si), 0);
        step(1'b0, 1'b0);
        chk("collide_one_cycle", int'(sr_enable), 0);
        space(3);
        chk("collide_valid", int'(letter_valid), 1);
        chk("collide_len", int'(letter_len), 1);
        chk("collide_q", int'(q_m), 0);
        do_ack();

        // consumer stalls while the key keeps moving
        mark(1);
        space(1);
        mark(3);
        space(3);
        chk("stall_q", int'(q_m), 5'b00001);
        base = pulses;
        for (int i = 0; i < 20; i++) begin
            step(i % 2 == 0, i % 4 == 3);
            chk("stall_valid", int'(letter_valid), 1);
            chk("stall_len", int'(letter_len), 2);
            chk("stall_ovf", int'(letter_ovf), 0);
        end
        chk("stall_no_shift", pulses - base, 0);
        do_ack();

        chk("no_enable_during_clear", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
